// File: rtl/pll_reset_sequencer.sv
// Reset sequencer behind the PLL: qualifies the asynchronous lock flag, then releases a
// synchronously deasserted system reset and counts lock losses seen while running.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  clear_loss,
    output logic                  sys_reset,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    // Guard the width so a 1-cycle qualify/hold setting still yields a legal vector
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
    logic [LOSS_CNT_W-1:0]  loss_base_s;
    logic                   loss_inc_s;
    logic                   sys_reset_q;
    logic                   ready_q;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock flag synchronizer chain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // Next-state, shared counter and loss-event decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lock_s) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUALIFY: begin
                if (!lock_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == QUAL_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    loss_inc_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear takes effect before a same-edge increment; the count saturates at all-ones
    always_comb begin
        loss_base_s = clear_loss ? '0 : loss_q;
        if (loss_inc_s && (loss_base_s != '1)) begin
            loss_d = loss_base_s + LOSS_CNT_W'(1);
        end else begin
            loss_d = loss_base_s;
        end
    end

    // State, counter, loss count and glitch-free outputs loaded from next-state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            loss_q      <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small qualify/hold windows and a 2-bit loss counter.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       clear_loss;
    logic       sys_reset;
    logic       ready;
    logic [1:0] state;
    logic [1:0] loss_count;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .LOSS_CNT_W         (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .clear_loss (clear_loss),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .state      (state),
        .loss_count (loss_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edge numbering: edge 1 first samples pll_lock=1; QUALIFY at 3, HOLD at 11, RUN at 15
    task automatic lock_up(input int first);
        logic [1:0] exp_st;
        pll_lock = 1'b1;
        for (int e = first; e <= 15; e++) begin
            tick();
            exp_st = (e < 3) ? 2'd0 : (e < 11) ? 2'd1 : (e < 15) ? 2'd2 : 2'd3;
            chk("lock_state", 32'(state), 32'(exp_st));
            if (e >= 14) begin
                chk("lock_sys_reset", 32'(sys_reset), (e < 15) ? 32'd1 : 32'd0);
                chk("lock_ready", 32'(ready), (e < 15) ? 32'd0 : 32'd1);
            end
        end
    endtask

    // Loss is seen on the third edge after the first low sample
    task automatic lose_lock(input logic [1:0] exp_loss, input bit clr);
        pll_lock = 1'b0;
        tick();
        chk("loss_e1_state", 32'(state), 32'd3);
        chk("loss_e1_sys_reset", 32'(sys_reset), 32'd0);
        tick();
        chk("loss_e2_state", 32'(state), 32'd3);
        if (clr) clear_loss = 1'b1;
        tick();
        clear_loss = 1'b0;
        chk("loss_e3_state", 32'(state), 32'd0);
        chk("loss_e3_sys_reset", 32'(sys_reset), 32'd1);
        chk("loss_e3_ready", 32'(ready), 32'd0);
        chk("loss_e3_count", 32'(loss_count), 32'(exp_loss));
    endtask

    initial begin
        reset      = 1'b1;
        pll_lock   = 1'b0;
        clear_loss = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sys_reset", 32'(sys_reset), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_loss", 32'(loss_count), 32'd0);
        reset = 1'b0;

        // Clean lock, then a loss in RUN
        lock_up(1);
        lose_lock(2'd1, 1'b0);

        // Async reset mid-cycle while running
        lock_up(1);
        #3;
        reset    = 1'b1;
        pll_lock = 1'b0;
        #1;
        chk("async_sys_reset", 32'(sys_reset), 32'd1);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_loss", 32'(loss_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_state", 32'(state), 32'd0);

        // One-cycle dropout while the qualify counter is at 5
        pll_lock = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("glitch_pre_state", 32'(state), (e < 3) ? 32'd0 : 32'd1);
        end
        pll_lock = 1'b0;
        tick();
        chk("glitch_e9_state", 32'(state), 32'd1);
        pll_lock = 1'b1;
        tick();
        chk("glitch_e10_state", 32'(state), 32'd1);
        tick();
        chk("glitch_idle_state", 32'(state), 32'd0);
        chk("glitch_idle_loss", 32'(loss_count), 32'd0);
        lock_up(3);
        chk("glitch_run_loss", 32'(loss_count), 32'd0);

        // Five losses against a 2-bit saturating counter
        lose_lock(2'd1, 1'b0);
        lock_up(1);
        lose_lock(2'd2, 1'b0);
        lock_up(1);
        lose_lock(2'd3, 1'b0);
        lock_up(1);
        lose_lock(2'd3, 1'b0);
        lock_up(1);
        lose_lock(2'd3, 1'b0);

        clear_loss = 1'b1;
        tick();
        clear_loss = 1'b0;
        chk("clear_from_sat", 32'(loss_count), 32'd0);

        // Clear coinciding with a loss, starting from a count of 2
        lock_up(1);
        lose_lock(2'd1, 1'b0);
        lock_up(1);
        lose_lock(2'd2, 1'b0);
        lock_up(1);
        lose_lock(2'd1, 1'b1);
        clear_loss = 1'b1;
        tick();
        clear_loss = 1'b0;
        chk("clear_alone", 32'(loss_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
